bank_queue_dispatcher: RTL and testbench

- Parametrised customer-queue controller for the branch lobby.
- Tracks the number of waiting customers and issues sequential ticket numbers on arrival.
- Dispatches waiting customers to N_TELLERS service windows using a round-robin arbiter.
- Sits between the lobby entry button/sensor logic and the teller call-display driver; saturating count plus overflow/underflow reporting.

---
 rtl/bank_queue_dispatcher.sv | 144 ++++++++++++++
 tb/tb_bank_queue_dispatcher.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_queue_dispatcher.sv
// Lobby queue controller: counts waiting customers, issues tickets and calls them round-robin to tellers.
// Optional macro BANK_QUEUE_ARRIVE_EDGE_EN turns arrive into a registered rising-edge detected pulse.
module bank_queue_dispatcher #(
    parameter int CNT_W     = 4,
    parameter int MAX_COUNT = 15,
    parameter int N_TELLERS = 3,
    parameter int TICKET_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arrive,
    input  logic [N_TELLERS-1:0] teller_req,
    output logic [CNT_W-1:0]     pcount,
    output logic                 full,
    output logic                 empty,
    output logic                 issue_valid,
    output logic [TICKET_W-1:0]  issue_ticket,
    output logic                 call_valid,
    output logic [2:0]           call_teller,
    output logic [TICKET_W-1:0]  call_ticket,
    output logic                 overflow,
    output logic                 underflow
);

    logic [CNT_W-1:0]    r_pcount;
    logic                r_full;
    logic                r_empty;
    logic                r_issue_valid;
    logic [TICKET_W-1:0] r_issue_ticket;
    logic                r_call_valid;
    logic [2:0]          r_call_teller;
    logic [TICKET_W-1:0] r_call_ticket;
    logic                r_overflow;
    logic                r_underflow;
    logic [TICKET_W-1:0] r_next_ticket;
    logic [TICKET_W-1:0] r_serve_ticket;
    logic [2:0]          r_rr_ptr;

    logic                w_arrive;
    logic                w_grant;
    logic [2:0]          w_winner;
    logic                w_accept;
    logic [CNT_W-1:0]    w_pcount_next;

`ifdef BANK_QUEUE_ARRIVE_EDGE_EN
    logic r_arrive_prev;
    logic r_arrive_pulse;

    // Registered edge pulse; prev resets to 0 so a level held through reset still counts once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arrive_prev  <= 1'b0;
            r_arrive_pulse <= 1'b0;
        end else begin
            r_arrive_prev  <= arrive;
            r_arrive_pulse <= arrive & ~r_arrive_prev;
        end
    end

    assign w_arrive = r_arrive_pulse;
`else
    assign w_arrive = arrive;
`endif

    // Round-robin: first pass covers rr_ptr..N-1, second pass wraps to the lowest requester
    always_comb begin
        w_grant  = 1'b0;
        w_winner = 3'd0;
        if (r_pcount != '0) begin
            for (int i = 0; i < N_TELLERS; i++) begin
                if (!w_grant && (i >= int'(r_rr_ptr)) && teller_req[i]) begin
                    w_grant  = 1'b1;
                    w_winner = 3'(i);
                end
            end
            for (int i = 0; i < N_TELLERS; i++) begin
                if (!w_grant && teller_req[i]) begin
                    w_grant  = 1'b1;
                    w_winner = 3'(i);
                end
            end
        end
    end

    // A grant in the same cycle frees a slot, so a full queue can still take an arrival
    assign w_accept = w_arrive && ((r_pcount < CNT_W'(MAX_COUNT)) || w_grant);

    always_comb begin
        w_pcount_next = r_pcount;
        if (w_accept && !w_grant) begin
            w_pcount_next = r_pcount + 1'b1;
        end else if (!w_accept && w_grant) begin
            w_pcount_next = r_pcount - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcount       <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_issue_valid  <= 1'b0;
            r_issue_ticket <= '0;
            r_call_valid   <= 1'b0;
            r_call_teller  <= 3'd0;
            r_call_ticket  <= '0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_next_ticket  <= '0;
            r_serve_ticket <= '0;
            r_rr_ptr       <= 3'd0;
        end else begin
            r_pcount      <= w_pcount_next;
            r_full        <= (w_pcount_next == CNT_W'(MAX_COUNT));
            r_empty       <= (w_pcount_next == '0);
            r_issue_valid <= w_accept;
            r_call_valid  <= w_grant;
            r_overflow    <= w_arrive && !w_accept;
            r_underflow   <= (|teller_req) && (r_pcount == '0);
            if (w_accept) begin
                r_issue_ticket <= r_next_ticket;
                r_next_ticket  <= r_next_ticket + 1'b1;
            end
            if (w_grant) begin
                r_call_teller  <= w_winner;
                r_call_ticket  <= r_serve_ticket;
                r_serve_ticket <= r_serve_ticket + 1'b1;
                r_rr_ptr       <= (w_winner == 3'(N_TELLERS - 1)) ? 3'd0 : w_winner + 3'd1;
            end
        end
    end

    assign pcount       = r_pcount;
    assign full         = r_full;
    assign empty        = r_empty;
    assign issue_valid  = r_issue_valid;
    assign issue_ticket = r_issue_ticket;
    assign call_valid   = r_call_valid;
    assign call_teller  = r_call_teller;
    assign call_ticket  = r_call_ticket;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_bank_queue_dispatcher.sv
// Bench for bank_queue_dispatcher: hand-computed vector table, queue-model scoreboard and corner sequences.
// With BANK_QUEUE_ARRIVE_EDGE_EN defined only the edge-detector sequence is run.
module tb_bank_queue_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       arrive;
    logic [2:0] teller_req;
    logic [3:0] pcount;
    logic       full;
    logic       empty;
    logic       issue_valid;
    logic [7:0] issue_ticket;
    logic       call_valid;
    logic [2:0] call_teller;
    logic [7:0] call_ticket;
    logic       overflow;
    logic       underflow;

    bank_queue_dispatcher dut (
        .clk          (clk),
        .reset        (reset),
        .arrive       (arrive),
        .teller_req   (teller_req),
        .pcount       (pcount),
        .full         (full),
        .empty        (empty),
        .issue_valid  (issue_valid),
        .issue_ticket (issue_ticket),
        .call_valid   (call_valid),
        .call_teller  (call_teller),
        .call_ticket  (call_ticket),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       arr;
        logic [2:0] req;
        logic       iv;
        int         it;
        logic       cv;
        int         ct;
        int         ctk;
        int         pc;
        logic       ov;
        logic       uf;
    } vec_t;

    typedef struct packed {
        logic iv;
        int   it;
        logic cv;
        int   ct;
        int   ctk;
        int   pc;
        logic ov;
        logic uf;
    } exp_t;

    vec_t vecs [19];
    exp_t sbq [$];
    int   mWait [$];
    int   mNext;
    int   mRr;
    int   nChecks = 0;
    int   nPassed = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPassed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic doReset();
        reset      = 1'b1;
        arrive     = 1'b0;
        teller_req = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mWait.delete();
        sbq.delete();
        mNext = 0;
        mRr   = 0;
    endtask

    // Reference: a queue of waiting ticket numbers, served from the front
    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sbq.pop_front();
        check("sb_pcount", int'(pcount), e.pc);
        check("sb_full", int'(full), int'(e.pc == 15));
        check("sb_empty", int'(empty), int'(e.pc == 0));
        check("sb_issue_valid", int'(issue_valid), int'(e.iv));
        check("sb_call_valid", int'(call_valid), int'(e.cv));
        check("sb_overflow", int'(overflow), int'(e.ov));
        check("sb_underflow", int'(underflow), int'(e.uf));
        if (e.iv) check("sb_issue_ticket", int'(issue_ticket), e.it);
        if (e.cv) begin
            check("sb_call_teller", int'(call_teller), e.ct);
            check("sb_call_ticket", int'(call_ticket), e.ctk);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic [2:0] r);
        exp_t e;
        int   cnt;
        int   win;
        logic grant;
        logic accept;
        cnt   = mWait.size();
        grant = 1'b0;
        win   = 0;
        if (cnt > 0) begin
            for (int k = 0; k < 3; k++) begin
                if (!grant && r[(mRr + k) % 3]) begin
                    grant = 1'b1;
                    win   = (mRr + k) % 3;
                end
            end
        end
        accept = a && (cnt < 15 || grant);
        e      = '0;
        e.cv   = grant;
        e.ct   = win;
        if (grant) begin
            e.ctk = mWait.pop_front();
            mRr   = (win + 1) % 3;
        end
        e.iv = accept;
        e.it = mNext;
        if (accept) begin
            mWait.push_back(mNext);
            mNext = (mNext + 1) % 256;
        end
        e.ov = a && !accept;
        e.uf = (|r) && (cnt == 0);
        e.pc = mWait.size();
        sbq.push_back(e);
        arrive     = a;
        teller_req = r;
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        reset      = 1'b1;
        arrive     = 1'b0;
        teller_req = 3'b000;
        // arr, req, iv, it, cv, ct, ctk, pc, ov, uf
        vecs[0]  = '{1'b1, 3'b000, 1'b1, 0, 1'b0, 0, 0, 1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 3'b000, 1'b1, 1, 1'b0, 0, 0, 2, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 1'b1, 2, 1'b0, 0, 0, 3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'b111, 1'b0, 0, 1'b1, 0, 0, 2, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 3'b110, 1'b0, 0, 1'b1, 1, 1, 1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'b100, 1'b0, 0, 1'b1, 2, 2, 0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'b000, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 3'b000, 1'b1, 3, 1'b0, 0, 0, 1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 3'b000, 1'b1, 4, 1'b0, 0, 0, 2, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'b111, 1'b0, 0, 1'b1, 0, 3, 1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'b110, 1'b0, 0, 1'b1, 1, 4, 0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 3'b100, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 3'b000, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 3'b000, 1'b1, 5, 1'b0, 0, 0, 1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 3'b001, 1'b1, 6, 1'b1, 0, 5, 1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 3'b000, 1'b0, 0, 1'b0, 0, 0, 1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 3'b010, 1'b0, 0, 1'b1, 1, 6, 0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 3'b100, 1'b1, 7, 1'b0, 0, 0, 1, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 3'b100, 1'b0, 0, 1'b1, 2, 7, 0, 1'b0, 1'b0};

        doReset();

`ifdef BANK_QUEUE_ARRIVE_EDGE_EN
        arrive = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("edge_iv_c%0d", k), int'(issue_valid), int'(k == 2));
            if (k == 2) check("edge_ticket", int'(issue_ticket), 0);
        end
        arrive = 1'b0;
        @(negedge clk);
        check("edge_pcount", int'(pcount), 1);
        check("edge_empty", int'(empty), 0);
`else
        check("rst_pcount", int'(pcount), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_issue_valid", int'(issue_valid), 0);
        check("rst_call_valid", int'(call_valid), 0);
        check("rst_issue_ticket", int'(issue_ticket), 0);
        check("rst_call_ticket", int'(call_ticket), 0);
        check("rst_call_teller", int'(call_teller), 0);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].arr, vecs[i].req);
            check($sformatf("tbl%0d_pcount", i), int'(pcount), vecs[i].pc);
            check($sformatf("tbl%0d_iv", i), int'(issue_valid), int'(vecs[i].iv));
            check($sformatf("tbl%0d_cv", i), int'(call_valid), int'(vecs[i].cv));
            check($sformatf("tbl%0d_ov", i), int'(overflow), int'(vecs[i].ov));
            check($sformatf("tbl%0d_uf", i), int'(underflow), int'(vecs[i].uf));
            if (vecs[i].iv) check($sformatf("tbl%0d_it", i), int'(issue_ticket), vecs[i].it);
            if (vecs[i].cv) begin
                check($sformatf("tbl%0d_ct", i), int'(call_teller), vecs[i].ct);
                check($sformatf("tbl%0d_ctk", i), int'(call_ticket), vecs[i].ctk);
            end
        end

        // Fill to capacity (tickets 8..22), then one rejected arrival
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 3'b000);
        check("fill_full", int'(full), 1);
        check("fill_pcount", int'(pcount), 15);
        check("fill_last_ticket", int'(issue_ticket), 22);
        applyStimulus(1'b1, 3'b000);
        check("fill_overflow", int'(overflow), 1);
        check("fill_reject_iv", int'(issue_valid), 0);
        check("fill_reject_pcount", int'(pcount), 15);

        // Full queue, arrival and teller 2 together: grant frees the slot
        applyStimulus(1'b1, 3'b100);
        check("fullsim_cv", int'(call_valid), 1);
        check("fullsim_teller", int'(call_teller), 2);
        check("fullsim_call_ticket", int'(call_ticket), 8);
        check("fullsim_iv", int'(issue_valid), 1);
        check("fullsim_issue_ticket", int'(issue_ticket), 23);
        check("fullsim_pcount", int'(pcount), 15);
        check("fullsim_overflow", int'(overflow), 0);
        applyStimulus(1'b0, 3'b000);

        // Continuous serve loop through the 255->0 ticket wrap; in-flight distance stays 15
        for (int i = 0; i < 280; i++) begin
            applyStimulus(1'b1, 3'(1 << (i % 3)));
            check("wrap_distance", (int'(issue_ticket) - int'(call_ticket)) & 255, 15);
        end

        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 3'b001);
        check("drain_empty", int'(empty), 1);

        // Asynchronous reset in the middle of operation
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b000);
        #2 reset = 1'b1;
        #1;
        check("midrst_pcount", int'(pcount), 0);
        check("midrst_empty", int'(empty), 1);
        doReset();
        applyStimulus(1'b1, 3'b000);
        check("midrst_ticket", int'(issue_ticket), 0);
        applyStimulus(1'b0, 3'b000);
`endif

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
